// File: rtl/proc_loader_pkg.sv
// Shared types and constants for the processor memory loader.
package proc_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VERIFY,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam int unsigned WORD_BYTES = 4;

  // Byte address forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/proc_loader_sum.sv
// 32-bit clearable accumulator, wraps modulo 2^32.
module proc_loader_sum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sum
);

  logic [31:0] r_sum;

  // Clear has priority over accumulate so a new load always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
    end else if (clr) begin
      r_sum <= '0;
    end else if (en) begin
      r_sum <= r_sum + din;
    end
  end

  assign sum = r_sum;

endmodule

// File: rtl/proc_mem_loader.sv
// Loads a word stream into processor data memory, reads it back, compares
// write/readback checksums, and releases the processor only on a match.
//
// state  | meaning
// IDLE   | waiting for start, processor held in reset
// WRITE  | accepting stream words and issuing one write per accepted word
// VERIFY | one read per cycle over the loaded range, summing read data
// CHECK  | compare write sum with verify sum
// DONE   | load good, processor released
// ERROR  | checksum mismatch, processor held in reset
module proc_mem_loader
  import proc_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      start_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic             in_val,
  input  logic [31:0]      in_data,
  output logic             in_rdy,
  output logic             ext_dmemreq_val,
  output logic             ext_dmemreq_type,
  output logic [31:0]      ext_dmemreq_addr,
  output logic [31:0]      ext_dmemreq_wdata,
  input  logic [31:0]      ext_dmemresp_rdata,
  output logic             proc_rst,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]      ADDR_INC = 32'(WORD_BYTES);

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_rd_addr;
  logic             r_req_val;
  logic             r_req_type;
  logic [31:0]      r_req_addr;
  logic [31:0]      r_req_wdata;
  logic             r_proc_rst;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic             w_start_ok;
  logic             w_hs;
  logic             w_in_verify;
  logic             w_rd_val;
  logic [CNT_W-1:0] w_rd_cnt_inc;
  logic             w_wr_sum_en;
  logic [31:0]      w_wr_sum;
  logic [31:0]      w_rd_sum;

  assign w_start_ok   = start && (r_state inside {IDLE, DONE, ERROR});
  assign in_rdy       = (r_state == WRITE) && (r_acc_cnt != r_num);
  assign w_hs         = in_val && in_rdy;
  assign w_in_verify  = (r_state == VERIFY);
  assign w_rd_val     = w_in_verify && (r_rd_cnt != r_num);
  assign w_rd_cnt_inc = r_rd_cnt + CNT_ONE;
  assign w_wr_sum_en  = r_req_val && (r_req_type == MEMREQ_WRITE);

  proc_loader_sum u_wr_sum (
    .clk (clk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (w_wr_sum_en),
    .din (r_req_wdata),
    .sum (w_wr_sum)
  );

  proc_loader_sum u_rd_sum (
    .clk (clk),
    .rst (rst),
    .clr (w_start_ok),
    .en  (w_rd_val),
    .din (ext_dmemresp_rdata),
    .sum (w_rd_sum)
  );

  // Reads are decoded straight from the state/address registers so read data
  // returned in the same cycle can be summed without an extra pipeline stage.
  assign ext_dmemreq_val   = w_in_verify ? w_rd_val    : r_req_val;
  assign ext_dmemreq_type  = w_in_verify ? MEMREQ_READ : r_req_type;
  assign ext_dmemreq_addr  = w_in_verify ? r_rd_addr   : r_req_addr;
  assign ext_dmemreq_wdata = r_req_wdata;

  assign proc_rst = r_proc_rst;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign checksum = w_wr_sum;

  // Sequencer: state, counters, address pointers, write issue stage, status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_num       <= '0;
      r_acc_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_req_val   <= 1'b0;
      r_req_type  <= MEMREQ_READ;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_proc_rst  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_req_val  <= 1'b0;
      r_req_type <= MEMREQ_READ;
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (w_start_ok) begin
            r_num      <= num_words;
            r_acc_cnt  <= '0;
            r_rd_cnt   <= '0;
            r_wr_addr  <= align_word(start_addr);
            r_rd_addr  <= align_word(start_addr);
            r_state    <= WRITE;
            r_proc_rst <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
          end
        end
        WRITE: begin
          if (w_hs) begin
            r_req_val   <= 1'b1;
            r_req_type  <= MEMREQ_WRITE;
            r_req_addr  <= r_wr_addr;
            r_req_wdata <= in_data;
            r_wr_addr   <= r_wr_addr + ADDR_INC;
            r_acc_cnt   <= r_acc_cnt + CNT_ONE;
          end
          // Once all words are accepted the stage holds at most the last
          // word, which issues this cycle, so it is drained by the next one.
          if (r_acc_cnt == r_num) begin
            r_state <= VERIFY;
          end
        end
        VERIFY: begin
          if (w_rd_val) begin
            r_rd_addr <= r_rd_addr + ADDR_INC;
            r_rd_cnt  <= w_rd_cnt_inc;
          end
          if (!w_rd_val || (w_rd_cnt_inc == r_num)) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          r_busy <= 1'b0;
          if (w_wr_sum == w_rd_sum) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_proc_rst <= 1'b0;
          end else begin
            r_state <= ERROR;
            r_error <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_mem_loader.sv
// Randomized self-checking bench for proc_mem_loader with a word-indexed
// memory model and a transaction-level expectation queue.
module tb_proc_mem_loader;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      start_addr = '0;
  logic [CNT_W-1:0] num_words = '0;
  logic             in_val = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_rdy;
  logic             ext_dmemreq_val;
  logic             ext_dmemreq_type;
  logic [31:0]      ext_dmemreq_addr;
  logic [31:0]      ext_dmemreq_wdata;
  logic [31:0]      ext_dmemresp_rdata;
  logic             proc_rst;
  logic             busy;
  logic             done;
  logic             error;
  logic [31:0]      checksum;

  proc_mem_loader #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .start_addr         (start_addr),
    .num_words          (num_words),
    .in_val             (in_val),
    .in_data            (in_data),
    .in_rdy             (in_rdy),
    .ext_dmemreq_val    (ext_dmemreq_val),
    .ext_dmemreq_type   (ext_dmemreq_type),
    .ext_dmemreq_addr   (ext_dmemreq_addr),
    .ext_dmemreq_wdata  (ext_dmemreq_wdata),
    .ext_dmemresp_rdata (ext_dmemresp_rdata),
    .proc_rst           (proc_rst),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .checksum           (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 256 words indexed by address bits [9:2], optional bit-0 flip on readback.
  logic [31:0] mem [0:255];
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;

  assign ext_dmemresp_rdata = mem[ext_dmemreq_addr[9:2]] ^
                              {31'd0, (corrupt_en && (ext_dmemreq_addr == corrupt_addr))};

  always @(posedge clk)
    if (ext_dmemreq_val && ext_dmemreq_type) mem[ext_dmemreq_addr[9:2]] <= ext_dmemreq_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  // Expected transactions for the current load.
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [31:0] exp_ra[$];
  int          hs_q[$];
  int          wr_seen;
  int          first_wr_cyc;
  int          first_rd_cyc;
  int          last_rd_cyc;
  logic [31:0] first_wr_addr;
  logic [31:0] last_wr_addr;
  bit          mon_en = 1'b0;

  logic [31:0] words [0:31];

  // Per-cycle compare against the expectation queues and global invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_val && in_rdy) hs_q.push_back(cyc);
      chk("proc_rst_eq_not_done", {31'd0, proc_rst}, {31'd0, ~done});
      if (in_rdy) chk("rdy_implies_busy", {31'd0, busy}, 32'd1);
      if (ext_dmemreq_val) chk("req_while_proc_rst", {31'd0, proc_rst}, 32'd1);
      if (ext_dmemreq_val && ext_dmemreq_type) begin
        if (exp_wa.size() == 0 || hs_q.size() == 0) begin
          fail("unexpected_write", ext_dmemreq_addr, 32'd0);
        end else begin
          chk("write_latency", cyc, hs_q.pop_front() + 1);
          chk("write_addr", ext_dmemreq_addr, exp_wa.pop_front());
          chk("write_data", ext_dmemreq_wdata, exp_wd.pop_front());
        end
        if (wr_seen == 0) begin
          first_wr_cyc  = cyc;
          first_wr_addr = ext_dmemreq_addr;
        end
        last_wr_addr = ext_dmemreq_addr;
        wr_seen++;
      end
      if (ext_dmemreq_val && !ext_dmemreq_type) begin
        if (exp_ra.size() == 0) fail("unexpected_read", ext_dmemreq_addr, 32'd0);
        else chk("read_addr", ext_dmemreq_addr, exp_ra.pop_front());
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        else chk("read_back_to_back", cyc, last_rd_cyc + 1);
        last_rd_cyc = cyc;
      end
    end
  end

  task automatic run_load(input logic [31:0] base, input int n, input int stall,
                          input bit pulse, input int abort_after, input string tag);
    logic [31:0] a;
    logic [31:0] s;
    bit          exp_err;
    bit          tog;
    bit          pend;
    int          idx;
    int          budget;
    int          scyc;
    int          dcyc;
    a = base & 32'hFFFF_FFFC;
    s = '0;
    exp_err = 1'b0;
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); hs_q.delete();
    wr_seen = 0; first_wr_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1;
    for (int k = 0; k < n; k++) begin
      exp_wa.push_back(a);
      exp_wd.push_back(words[k]);
      exp_ra.push_back(a);
      s = s + words[k];
      if (corrupt_en && a == corrupt_addr) exp_err = 1'b1;
      a = a + 32'd4;
    end
    @(posedge clk); #1;
    start = 1'b1; start_addr = base; num_words = CNT_W'(n); in_val = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    scyc = cyc;
    chk({tag, " proc_rst_after_start"}, {31'd0, proc_rst}, 32'd1);
    chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({tag, " done_after_start"}, {31'd0, done}, 32'd0);
    chk({tag, " checksum_cleared"}, checksum, 32'd0);
    idx = 0; budget = 4000; tog = 1'b1; pend = pulse;
    while (!(done || error) && budget > 0) begin
      case (stall)
        0: in_val = 1'b1;
        1: begin in_val = tog; tog = !tog; end
        default: in_val = 1'($urandom_range(0, 1));
      endcase
      in_data = (idx < n) ? words[idx] : $urandom;
      if (pend && idx == 1) begin
        start = 1'b1; start_addr = 32'hDEAD_0000; num_words = CNT_W'(7); pend = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (abort_after >= 0 && wr_seen >= abort_after) begin
        #2 rst = 1'b1;
        #1;
        chk({tag, " rst proc_rst"}, {31'd0, proc_rst}, 32'd1);
        chk({tag, " rst busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " rst req_val"}, {31'd0, ext_dmemreq_val}, 32'd0);
        chk({tag, " rst req_type"}, {31'd0, ext_dmemreq_type}, 32'd0);
        chk({tag, " rst req_addr"}, ext_dmemreq_addr, 32'd0);
        chk({tag, " rst req_wdata"}, ext_dmemreq_wdata, 32'd0);
        chk({tag, " rst in_rdy"}, {31'd0, in_rdy}, 32'd0);
        chk({tag, " rst done"}, {31'd0, done}, 32'd0);
        chk({tag, " rst error"}, {31'd0, error}, 32'd0);
        chk({tag, " rst checksum"}, checksum, 32'd0);
        in_val = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); hs_q.delete();
        return;
      end
      if (in_val && in_rdy) idx++;
      @(posedge clk); #1;
      budget--;
    end
    start = 1'b0;
    in_val = 1'b0;
    dcyc = cyc;
    if (budget == 0) begin
      fail({tag, " timeout"}, {29'd0, busy, done, error}, 32'd0);
    end else begin
      chk({tag, " done"}, {31'd0, done}, {31'd0, !exp_err});
      chk({tag, " error"}, {31'd0, error}, {31'd0, exp_err});
      chk({tag, " proc_rst_final"}, {31'd0, proc_rst}, {31'd0, exp_err});
      chk({tag, " busy_final"}, {31'd0, busy}, 32'd0);
      chk({tag, " checksum"}, checksum, s);
      chk({tag, " writes_left"}, exp_wa.size(), 32'd0);
      chk({tag, " reads_left"}, exp_ra.size(), 32'd0);
      chk({tag, " write_count"}, wr_seen, n);
      if (stall == 0) begin
        chk({tag, " done_cycle"}, dcyc, scyc + (n + 1) + ((n > 0) ? n : 1) + 1);
        if (n > 0) begin
          chk({tag, " first_write_cycle"}, first_wr_cyc, scyc + 1);
          chk({tag, " first_read_cycle"}, first_rd_cyc, scyc + n + 1);
        end
      end
    end
  endtask

  initial begin
    int          n;
    logic [31:0] base;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("init proc_rst", {31'd0, proc_rst}, 32'd1);
    chk("init busy", {31'd0, busy}, 32'd0);
    chk("init done", {31'd0, done}, 32'd0);
    chk("init error", {31'd0, error}, 32'd0);
    chk("init in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("init req_val", {31'd0, ext_dmemreq_val}, 32'd0);
    chk("init req_addr", ext_dmemreq_addr, 32'd0);
    chk("init checksum", checksum, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int k = 0; k < 4; k++) words[k] = 32'h11 + k;
    run_load(32'h200, 4, 0, 1'b0, 2, "rst_mid_write");

    for (int k = 0; k < 4; k++) words[k] = k + 1;
    run_load(32'h100, 4, 0, 1'b0, -1, "basic");
    chk("basic checksum literal", checksum, 32'h0000_000A);
    chk("basic first addr literal", first_wr_addr, 32'h0000_0100);

    words[0] = 32'hFFFF_FFFF; words[1] = 32'd2; words[2] = 32'd0;
    run_load(32'h3, 3, 1, 1'b1, -1, "stall");
    chk("stall checksum literal", checksum, 32'h0000_0001);
    chk("stall first addr literal", first_wr_addr, 32'h0000_0000);

    for (int k = 0; k < 4; k++) words[k] = 32'h5 + k;
    corrupt_en = 1'b1; corrupt_addr = 32'h104;
    run_load(32'h100, 4, 0, 1'b0, -1, "corrupt");
    chk("corrupt error literal", {31'd0, error}, 32'd1);
    corrupt_en = 1'b0;

    words[0] = $urandom; words[1] = $urandom;
    run_load(32'hFFFF_FFFC, 2, 0, 1'b0, -1, "wrap");
    chk("wrap first addr literal", first_wr_addr, 32'hFFFF_FFFC);
    chk("wrap last addr literal", last_wr_addr, 32'h0000_0000);

    run_load(32'h40, 0, 0, 1'b0, -1, "empty");
    chk("empty checksum literal", checksum, 32'd0);
    chk("empty no writes literal", wr_seen, 32'd0);

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, 20);
      base = $urandom;
      for (int k = 0; k < n; k++) words[k] = $urandom;
      corrupt_en = (n > 0) && ($urandom_range(0, 2) == 0);
      corrupt_addr = (base & 32'hFFFF_FFFC) + 32'(4 * $urandom_range(0, (n > 0) ? n - 1 : 0));
      run_load(base, n, 2, 1'($urandom_range(0, 1)), -1, "random");
      corrupt_en = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
